// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared FSM encoding, conversion step counts and Q8.8 widths for the square-root pipeline
package sqrt_pkg;
  typedef enum logic [1:0] {IDLE, INT_CONV, FRAC_CONV, DONE} state_t;
  localparam int DEF_INT_STEPS   = 8;
  localparam int DEF_FRAC_DIGITS = 3;
  localparam int Q_INT_W         = 8;
  localparam int Q_FRAC_W        = 8;
  localparam int Q_W             = Q_INT_W + Q_FRAC_W;
  localparam int BCD_W           = 12;
  localparam int CNT_W           = 4;
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one double-dabble iteration (add 3 to nibbles >= 5, then shift {bcd,bin} left by one)
module bcd_dabble_step
  import sqrt_pkg::*;
(
  input  logic [BCD_W-1:0]   bcd_in,
  input  logic [Q_INT_W-1:0] bin_in,
  output logic [BCD_W-1:0]   bcd_out,
  output logic [Q_INT_W-1:0] bin_out
);
  logic [BCD_W-1:0] adj;
  for (genvar i = 0; i < BCD_W / 4; i++) begin : g_nib
    assign adj[4*i +: 4] = bcd_in[4*i +: 4] >= 4'd5 ? bcd_in[4*i +: 4] + 4'd3 : bcd_in[4*i +: 4];
  end
  assign {bcd_out, bin_out} = {adj, bin_in} << 1;
endmodule

// File: rtl/sqrt_bcd_formatter.sv
// sqrt_bcd_formatter: converts a Q8.8 value to 3 integer BCD digits and 3 truncated fraction digits
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_data upstream handshake;
//        out_valid/out_ready downstream handshake; int_bcd/frac_bcd results, held in DONE.
module sqrt_bcd_formatter
  import sqrt_pkg::*;
#(
  parameter int INT_STEPS   = DEF_INT_STEPS,
  parameter int FRAC_DIGITS = DEF_FRAC_DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Q_W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BCD_W-1:0] int_bcd,
  output logic [BCD_W-1:0] frac_bcd
);
  state_t st, nxt;
  logic [CNT_W-1:0]    cnt;
  logic [Q_INT_W-1:0]  ib, nib;
  logic [Q_FRAC_W-1:0] fb;
  logic [BCD_W-1:0]    nbcd;
  logic [11:0]         p;
  logic                int_last, frac_last;

  bcd_dabble_step u_step (.bcd_in(int_bcd), .bin_in(ib), .bcd_out(nbcd), .bin_out(nib));

  // frac*10 without a multiplier; the integer digit lands in p[11:8]
  assign p         = {1'b0, fb, 3'b000} + {3'b000, fb, 1'b0};
  assign int_last  = cnt == CNT_W'(INT_STEPS - 1);
  assign frac_last = cnt == CNT_W'(FRAC_DIGITS - 1);

  always_ff @(posedge clk)
    st <= rst ? IDLE : nxt;

  always_comb begin
    nxt = st;
    case (st)
      IDLE:      nxt = in_valid ? INT_CONV : IDLE;
      INT_CONV:  nxt = int_last ? FRAC_CONV : INT_CONV;
      FRAC_CONV: nxt = frac_last ? DONE : FRAC_CONV;
      DONE:      nxt = out_ready ? IDLE : DONE;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = st == IDLE;
    out_valid = st == DONE;
  end

  always_ff @(posedge clk)
    if (rst) begin
      cnt      <= '0;
      ib       <= '0;
      fb       <= '0;
      int_bcd  <= '0;
      frac_bcd <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          ib       <= in_data[Q_W-1:Q_FRAC_W];
          fb       <= in_data[Q_FRAC_W-1:0];
          int_bcd  <= '0;
          frac_bcd <= '0;
          cnt      <= '0;
        end
        INT_CONV: begin
          int_bcd <= nbcd;
          ib      <= nib;
          cnt     <= int_last ? '0 : cnt + 1'b1;
        end
        FRAC_CONV: begin
          // digits shift in from the right so the first (tenths) ends up in the top nibble
          frac_bcd <= {frac_bcd[BCD_W-5:0], p[11:8]};
          fb       <= p[7:0];
          cnt      <= frac_last ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sqrt_bcd_formatter.sv
// tb_sqrt_bcd_formatter: directed self-checking bench for sqrt_bcd_formatter
module tb_sqrt_bcd_formatter;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [11:0] int_bcd;
  logic [11:0] frac_bcd;
  int cmp = 0;
  int errs = 0;

  sqrt_bcd_formatter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .int_bcd(int_bcd), .frac_bcd(frac_bcd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    cmp++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic run_item(input logic [15:0] d, input logic [11:0] ei, input logic [11:0] ef,
                          input int hold, input bit noise);
    int n;
    chk("pre_ready", 16'(in_ready), 16'd1);
    in_valid = 1;
    in_data  = d;
    tick();
    chk("busy_ready", 16'(in_ready), 16'd0);
    in_valid = noise;
    n = 0;
    while (!out_valid && n < 20) begin
      if (noise) in_data = 16'($urandom);
      tick();
      n++;
    end
    in_valid = 0;
    chk("latency", 16'(n), 16'd11);
    chk("int_bcd", 16'(int_bcd), 16'(ei));
    chk("frac_bcd", 16'(frac_bcd), 16'(ef));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 16'(out_valid), 16'd1);
      chk("hold_int", 16'(int_bcd), 16'(ei));
      chk("hold_frac", 16'(frac_bcd), 16'(ef));
      chk("hold_ready", 16'(in_ready), 16'd0);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("post_ready", 16'(in_ready), 16'd1);
    chk("post_valid", 16'(out_valid), 16'd0);
  endtask

  initial begin
    int n;
    bit seen;
    tick();
    tick();
    rst = 0;
    chk("rst_ready", 16'(in_ready), 16'd1);
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_int", 16'(int_bcd), 16'h000);
    chk("rst_frac", 16'(frac_bcd), 16'h000);

    out_ready = 1;
    tick();
    out_ready = 0;
    chk("idle_oready_valid", 16'(out_valid), 16'd0);
    chk("idle_oready_ready", 16'(in_ready), 16'd1);

    run_item(16'h016A, 12'h001, 12'h414, 0, 0);
    run_item(16'hFFFF, 12'h255, 12'h996, 0, 0);
    run_item(16'h0000, 12'h000, 12'h000, 0, 0);
    run_item(16'h0180, 12'h001, 12'h500, 0, 0);
    run_item(16'h016A, 12'h001, 12'h414, 5, 0);
    run_item(16'h0C40, 12'h012, 12'h250, 0, 1);

    in_valid = 1;
    in_data  = 16'hFFFF;
    tick();
    in_valid = 0;
    tick();
    tick();
    tick();
    rst = 1;
    tick();
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_int", 16'(int_bcd), 16'h000);
    chk("mid_rst_frac", 16'(frac_bcd), 16'h000);
    rst = 0;
    tick();
    chk("mid_rst_ready", 16'(in_ready), 16'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("mid_rst_no_output", 16'(seen), 16'd0);
    run_item(16'h0F10, 12'h015, 12'h062, 0, 0);

    in_valid  = 1;
    out_ready = 1;
    in_data   = 16'h0D80;
    tick();
    in_data = 16'h0280;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_lat_a", 16'(n), 16'd11);
    chk("b2b_int_a", 16'(int_bcd), 16'h013);
    chk("b2b_frac_a", 16'(frac_bcd), 16'h500);
    tick();
    chk("b2b_idle", 16'(in_ready), 16'd1);
    tick();
    chk("b2b_accept_13", 16'(in_ready), 16'd0);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_lat_b", 16'(n), 16'd11);
    chk("b2b_int_b", 16'(int_bcd), 16'h002);
    chk("b2b_frac_b", 16'(frac_bcd), 16'h500);
    tick();
    out_ready = 0;
    chk("b2b_end_ready", 16'(in_ready), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/sqrt_bcd_formatter.md
SQRT_BCD_FORMATTER -- requirements
Module: sqrt_bcd_formatter

Interface
REQ-001 SHALL have the parameters INT_STEPS, default 8, the number of double-dabble iterations, and FRAC_DIGITS, default 3, the number of decimal fraction digits produced.
REQ-002 SHALL have one clock and synchronous active-high reset, with ports listed clock and reset first.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  synchronous reset, active high.
REQ-005 in_valid  input  1  upstream square-root result present.
REQ-006 in_ready  output  1  block can accept in_data.
REQ-007 in_data  input  16  unsigned Q8.8 value; square-root results occupy bits [11:0] and zero-extend.
REQ-008 out_valid  output  1  decimal result available.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 int_bcd  output  12  three BCD digits of in_data[15:8], hundreds in [11:8].
REQ-011 frac_bcd  output  12  three decimal digits of in_data[7:0]/256, truncated; tenths in [11:8].

Function
REQ-012 SHALL implement FSM states IDLE, INT_CONV, FRAC_CONV and DONE.
REQ-013 IDLE: in_ready=1; on in_valid&&in_ready, load the integer byte, fraction byte and zeroed BCD registers, clear the step counter, and go to INT_CONV.
REQ-014 INT_CONV: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,int} left by 1; after INT_STEPS cycles go to FRAC_CONV.
REQ-015 FRAC_CONV: each cycle, p=frac*10 (12-bit), write the next digit as p[11:8], set frac=p[7:0]; after FRAC_DIGITS cycles go to DONE.
REQ-016 DONE: out_valid=1; int_bcd and frac_bcd SHALL be held stable until out_valid&&out_ready, then return to IDLE.
REQ-017 Latency SHALL be fixed: out_valid rises exactly INT_STEPS+FRAC_DIGITS (11) clock edges after the accepting edge, independent of data.
REQ-018 in_ready SHALL be 0 in INT_CONV, FRAC_CONV and DONE; in_valid in those states SHALL be ignored and SHALL NOT disturb the registers.
REQ-019 There SHALL be no same-cycle pass-through: a new input is accepted no earlier than the cycle after the output handshake, giving a minimum spacing of 13 cycles per item.
REQ-020 out_ready while out_valid=0 SHALL have no effect.
REQ-021 BCD digits SHALL never exceed 9; fraction conversion SHALL truncate and never round.
REQ-022 in_ready and out_valid SHALL be registered, decoded from state only, with no combinational path from inputs.

Reset
REQ-023 On rst=1 at a clock edge, regardless of state, the FSM SHALL go to IDLE and the counter, int_bcd and frac_bcd SHALL clear to 0.
REQ-024 In that same reset condition, out_valid SHALL be 0 and in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-025 Reset mid-conversion SHALL discard the item with no partial output.
REQ-026 rst SHALL take priority over simultaneous in_valid or out_ready.

Structure
REQ-027 The state encoding, INT_STEPS, FRAC_DIGITS and the Q8.8 width constants SHALL live in shared package sqrt_pkg, reused by the square-root stage.
REQ-028 One combinational sub-module, bcd_dabble_step (12-bit BCD plus 8-bit shift in, one add-3/shift iteration out), SHALL be instantiated for INT_CONV.
REQ-029 The fraction multiply-by-10 SHALL be done as (frac<<3)+(frac<<1), with no multiplier.

Verification
REQ-030 Bench SHALL check: in_data=0x016A (sqrt 2) -> int_bcd=0x001, frac_bcd=0x414, out_valid 11 edges after acceptance.
REQ-031 Bench SHALL check: in_data=0xFFFF -> int_bcd=0x255, frac_bcd=0x996; in_data=0x0000 -> 0x000/0x000; in_data=0x0180 -> 0x001/0x500.
REQ-032 Bench SHALL check: out_ready held 0 for 5 cycles in DONE -> outputs and out_valid stable; in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-033 Bench SHALL check: rst pulsed on the 4th INT_CONV cycle -> next edge shows out_valid=0, outputs 0 and in_ready=1 after release; the next item, 0x0F10, yields 0x015/0x062.
REQ-034 Bench SHALL check: in_valid=1 with changing in_data during busy -> result equals the first accepted value only.
REQ-035 Bench SHALL check: back-to-back items with out_ready=1 and in_valid=1 -> accepted 13 cycles apart, both results correct.
